load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Multi-cycle data-memory access stage between the ALU result/register-file read port and a handshaked data bus; replaces direct single-cycle data RAM access.
- Accepts one RV32I load/store at a time: byte address from the ALU, store data from rs2, funct3 size/sign code.
- Issues a word-aligned bus request with byte enables, waits for acknowledge, returns sign/zero-extended load data or store completion.
- Detects misaligned accesses, illegal funct3 and bus timeout.

Parameters:
TIMEOUT_CYCLES, 64, cycles mem_req may stay high without mem_ack before aborting; 0 disables timeout.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  core presents a memory operation
req_ready  output  1  unit idle, can accept; transfer when req_valid && req_ready
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address (ALU result)
req_wdata  input  32  store data (rs2), right-justified
rsp_valid  output  1  one-cycle pulse: operation finished
rsp_rdata  output  32  extended load data; 0 for stores and faults
rsp_fault  output  1  qualifies rsp_valid: operation failed
rsp_cause  output  2  01 misaligned, 10 bus timeout, 11 illegal funct3, 00 none
mem_req  output  1  bus request, held until mem_ack
mem_we  output  1  bus write strobe
mem_addr  output  32  word address, bits [1:0] = 00
mem_be  output  4  byte-lane enables
mem_wdata  output  32  lane-aligned store data
mem_ack  input  1  bus completion, sampled only while mem_req = 1
mem_rdata  input  32  read word, valid with mem_ack on loads

Behaviour:
- Reset (rst = 0, async): state IDLE, timeout counter 0, all registered outputs 0; req_ready = 1 (IDLE).
- States: IDLE, BUS, RESP. req_ready = (state == IDLE), combinational.
- IDLE, on accept: latch op fields. Illegal funct3 (011, 110, 111, or store with funct3[2] = 1) -> RESP, cause 11. Else misaligned (H/HU with addr[0] = 1; W with addr[1:0] != 00) -> RESP, cause 01; no bus transaction. Else -> BUS.
- Illegal checked before misaligned.
- BUS: mem_req = 1. mem_addr = {addr[31:2], 2'b00}, mem_we = req_we. All mem_* outputs stable for the whole request.
- mem_be, off = addr[1:0]: B/BU 0001 << off; H/HU 0011 << off; W 1111. Loads drive the same be.
- mem_wdata = byte/half replicated across lanes (B: {4{wdata[7:0]}}, H: {2{wdata[15:0]}}, W: wdata). Lanes not enabled are don't-care but replication is required.
- Latency: accept in cycle 0, mem_req = 1 from cycle 1.
- mem_ack in cycle k >= 1 -> mem_req = 0 in k+1 and RESP in k+1, so rsp_valid in k+1. Zero-wait bus gives rsp_valid in cycle 2.
- Load data captured on the ack edge. B: sign-extend byte at lane off. BU: zero-extend it. H/HU: halfword at lanes off..off+1, sign/zero-extended. W: whole word.
- Timeout: counter increments each BUS cycle without ack. On the cycle it equals TIMEOUT_CYCLES, drop mem_req next cycle, RESP with cause 10.
- Ack in the same cycle as timeout: ack wins, normal completion.
- Counter clears on entering BUS.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE; req_ready returns 1 the following cycle (no back-to-back accept in RESP).
- rsp_fault = (cause != 00). rsp_rdata = 0 unless a successful load. Outputs other than rsp_valid hold their last values until the next response.
- mem_ack outside BUS is ignored. req_valid while not ready is ignored; the core must hold it.
- Reset mid-BUS: mem_req drops immediately (async); no response is generated.

Test Plan:
- LB addr 0x0000_1003, bus rdata 0x80AA_BBCC, ack 1 cycle after mem_req -> mem_addr 0x1000, be 1000, rsp_rdata 0xFFFF_FF80, rsp_valid in cycle 2.
- LHU addr 0x0000_2002, rdata 0x9ABC_1234 -> be 1100, rsp_rdata 0x0000_9ABC. LH same address -> 0xFFFF_9ABC.
- SB addr 0x0000_0101, wdata 0x1234_56EF -> mem_we 1, be 0010, mem_wdata 0xEFEF_EFEF, rsp_fault 0, rsp_rdata 0.
- LW addr 0x0000_0006 -> no mem_req ever, rsp_valid cycle 1, rsp_fault 1, cause 01. SH funct3 101 -> cause 11.
- TIMEOUT_CYCLES = 4, mem_ack never asserted -> mem_req high exactly 5 cycles, then rsp cause 10. Ack on the 5th cycle -> normal response.
- Assert rst low while in BUS with mem_req = 1 -> mem_req, rsp_valid 0 immediately, req_ready 1. Next load after release completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store stage driving a req/ack data bus
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [1:0]  rsp_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_MISALGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic            accept;
  logic            illegal;
  logic            misaligned;
  logic            timeout_hit;
  logic [3:0]      be_d;
  logic [31:0]     wdata_d;

  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
      3'b100:  load_extend = {24'b0, sh[7:0]};
      3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
      3'b101:  load_extend = {16'b0, sh[15:0]};
      default: load_extend = word;
    endcase
  endfunction

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign mem_req   = (state_q == S_BUS);
  assign accept    = req_valid && req_ready;

  // Stores have no unsigned variants, so funct3[2] with a store is illegal too.
  assign illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                   (req_funct3 == 3'b111) || (req_we && req_funct3[2]);

  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES));

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << req_addr[1:0];
        wdata_d = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (illegal || misaligned) ? S_RESP : S_BUS;
      S_BUS:  if (mem_ack || timeout_hit) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus fields are latched at accept so they stay stable for the whole request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      funct3_q  <= 3'b000;
      off_q     <= 2'b00;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_fault <= 1'b0;
      rsp_cause <= CAUSE_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q    <= '0;
            funct3_q <= req_funct3;
            off_q    <= req_addr[1:0];
            if (illegal || misaligned) begin
              rsp_rdata <= 32'h0;
              rsp_fault <= 1'b1;
              rsp_cause <= illegal ? CAUSE_ILLEGAL : CAUSE_MISALGN;
            end else begin
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= be_d;
              mem_wdata <= wdata_d;
            end
          end
        end
        S_BUS: begin
          if (mem_ack) begin
            rsp_rdata <= mem_we ? 32'h0 : load_extend(funct3_q, off_q, mem_rdata);
            rsp_fault <= 1'b0;
            rsp_cause <= CAUSE_NONE;
          end else if (timeout_hit) begin
            rsp_rdata <= 32'h0;
            rsp_fault <= 1'b1;
            rsp_cause <= CAUSE_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [1:0]  rsp_cause;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .rsp_cause(rsp_cause),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request in IDLE; returns one cycle after the accept edge (cycle 1).
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    step();
    req_valid  = 1'b0;
  endtask

  // Issues, waits extra cycles, acks, and returns in the response cycle with bus fields seen at ack.
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                       output logic [31:0] a, output logic [3:0] be,
                       output logic [31:0] wd, output logic w, output logic r);
    issue(we, f3, addr, wdata);
    repeat (waits) step();
    a  = mem_addr;
    be = mem_be;
    wd = mem_wdata;
    w  = mem_we;
    r  = mem_req;
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    step();
    mem_ack   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic        w, r;
    int          n;

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) step();
    check("reset_ready", {31'b0, req_ready}, 32'd1);
    check("reset_mem_req", {31'b0, mem_req}, 32'd0);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rdata", rsp_rdata, 32'h0);
    check("reset_cause", {30'b0, rsp_cause}, 32'd0);
    rst = 1'b1;
    step();

    // LB, zero-wait bus: response in cycle 2
    issue(1'b0, 3'b000, 32'h0000_1003, 32'h0);
    check("lb_mem_req", {31'b0, mem_req}, 32'd1);
    check("lb_ready_busy", {31'b0, req_ready}, 32'd0);
    check("lb_addr", mem_addr, 32'h0000_1000);
    check("lb_be", {28'b0, mem_be}, 32'h8);
    check("lb_we", {31'b0, mem_we}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h80AA_BBCC;
    step();
    mem_ack = 1'b0;
    check("lb_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("lb_rdata", rsp_rdata, 32'hFFFF_FF80);
    check("lb_fault", {31'b0, rsp_fault}, 32'd0);
    check("lb_mem_req_drop", {31'b0, mem_req}, 32'd0);
    step();
    check("lb_rsp_pulse", {31'b0, rsp_valid}, 32'd0);
    check("lb_ready_back", {31'b0, req_ready}, 32'd1);
    check("lb_rdata_hold", rsp_rdata, 32'hFFFF_FF80);

    do_op(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h9ABC_1234, 0, a, be, wd, w, r);
    check("lhu_be", {28'b0, be}, 32'hC);
    check("lhu_rdata", rsp_rdata, 32'h0000_9ABC);
    step();
    do_op(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h9ABC_1234, 0, a, be, wd, w, r);
    check("lh_rdata", rsp_rdata, 32'hFFFF_9ABC);
    step();

    do_op(1'b1, 3'b000, 32'h0000_0101, 32'h1234_56EF, 32'hFFFF_FFFF, 0, a, be, wd, w, r);
    check("sb_we", {31'b0, w}, 32'd1);
    check("sb_addr", a, 32'h0000_0100);
    check("sb_be", {28'b0, be}, 32'h2);
    check("sb_wdata", wd, 32'hEFEF_EFEF);
    check("sb_valid", {31'b0, rsp_valid}, 32'd1);
    check("sb_fault", {31'b0, rsp_fault}, 32'd0);
    check("sb_rdata", rsp_rdata, 32'h0);
    step();

    do_op(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 1, a, be, wd, w, r);
    check("sh_be", {28'b0, be}, 32'hC);
    check("sh_wdata", wd, 32'hABCD_ABCD);
    step();

    // LW with two wait cycles: mem fields stable and still requesting at cycle 3
    do_op(1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'hDEAD_BEEF, 2, a, be, wd, w, r);
    check("lw_req_held", {31'b0, r}, 32'd1);
    check("lw_addr", a, 32'h0000_0044);
    check("lw_be", {28'b0, be}, 32'hF);
    check("lw_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("lw_valid", {31'b0, rsp_valid}, 32'd1);
    step();

    issue(1'b0, 3'b010, 32'h0000_0006, 32'h0);
    check("mis_mem_req", {31'b0, mem_req}, 32'd0);
    check("mis_valid", {31'b0, rsp_valid}, 32'd1);
    check("mis_fault", {31'b0, rsp_fault}, 32'd1);
    check("mis_cause", {30'b0, rsp_cause}, 32'd1);
    check("mis_rdata", rsp_rdata, 32'h0);
    step();
    check("mis_no_req_after", {31'b0, mem_req}, 32'd0);

    issue(1'b1, 3'b101, 32'h0000_0010, 32'h0);
    check("ill_sh_cause", {30'b0, rsp_cause}, 32'd3);
    check("ill_sh_mem_req", {31'b0, mem_req}, 32'd0);
    step();
    issue(1'b0, 3'b011, 32'h0000_0001, 32'h0);
    check("ill_before_mis", {30'b0, rsp_cause}, 32'd3);
    step();

    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("idle_ack_ignored", {31'b0, rsp_valid}, 32'd0);
    check("idle_ack_ready", {31'b0, req_ready}, 32'd1);

    issue(1'b0, 3'b010, 32'h0000_0010, 32'h0);
    n = 0;
    for (int i = 0; i < 20 && mem_req; i++) begin
      n++;
      step();
    end
    check("to_req_cycles", n, 32'd5);
    check("to_valid", {31'b0, rsp_valid}, 32'd1);
    check("to_cause", {30'b0, rsp_cause}, 32'd2);
    check("to_fault", {31'b0, rsp_fault}, 32'd1);
    check("to_rdata", rsp_rdata, 32'h0);
    step();

    do_op(1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'h1357_9BDF, 4, a, be, wd, w, r);
    check("ack5_req_held", {31'b0, r}, 32'd1);
    check("ack5_fault", {31'b0, rsp_fault}, 32'd0);
    check("ack5_cause", {30'b0, rsp_cause}, 32'd0);
    check("ack5_rdata", rsp_rdata, 32'h1357_9BDF);
    step();

    issue(1'b0, 3'b010, 32'h0000_0030, 32'h0);
    check("rst_pre_req", {31'b0, mem_req}, 32'd1);
    rst = 1'b0;
    #1;
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    step();
    rst = 1'b1;
    step();
    check("rst_no_rsp", {31'b0, rsp_valid}, 32'd0);

    do_op(1'b0, 3'b100, 32'h0000_0031, 32'h0, 32'h1234_F678, 0, a, be, wd, w, r);
    check("lbu_be", {28'b0, be}, 32'h2);
    check("lbu_valid", {31'b0, rsp_valid}, 32'd1);
    check("lbu_rdata", rsp_rdata, 32'h0000_00F6);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
